anita3_trigger_arbiter: RTL and testbench

// - Arbitrates the four trigger sources (RF, PPS1, PPS2, soft) in the clk250 domain ahead of the buffer manager.
// - Issues one merged trigger pulse with a one-hot-or-more source mask, then waits for the buffer manager's dead handshake.
// - Enforces a programmable holdoff and counts dropped (lost) triggers per source for the scaler block.

---
 rtl/anita3_trig_pkg.sv | 26 ++
 rtl/anita3_sat_counter.sv | 36 +++
 rtl/anita3_trigger_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_anita3_trigger_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/anita3_trig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anita3_trig_pkg
// Description : Shared constants for the ANITA-3 trigger arbiter.
//               - Trigger source bit positions within src_i / trig_src_o
//               - Arbiter FSM state encodings (visible on state_o)
// Revision    : 1.0 - initial release
// ============================================================================
package anita3_trig_pkg;

    // Bit position of each trigger source
    localparam int SRC_RF   = 0;
    localparam int SRC_PPS1 = 1;
    localparam int SRC_PPS2 = 2;
    localparam int SRC_SOFT = 3;

    // Arbiter states; the encoding is software-visible through state_o
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_BUSY    = 2'd2,
        ST_HOLDOFF = 2'd3
    } trig_state_e;

endpackage
`default_nettype wire

// File: rtl/anita3_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : anita3_sat_counter
// Description : Saturating up-counter used for per-source lost-trigger counts.
//               The clear input takes priority over an increment.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset
//               inc_i    - increment by one (holds at all-ones)
//               clr_i    - synchronous clear
//               value_o  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module anita3_sat_counter #(
    parameter int LOST_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [LOST_W-1:0] value_o
);

    logic [LOST_W-1:0] value_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            value_q <= '0;
        end else if (inc_i && (value_q != '1)) begin
            value_q <= value_q + LOST_W'(1);
        end
    end

    assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/anita3_trigger_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : anita3_trigger_arbiter
// Description : Merges the RF, PPS1, PPS2 and soft trigger sources into a
//               single 1-cycle trigger pulse with a source mask, waits for
//               the buffer manager's dead handshake, applies a programmable
//               holdoff and counts dropped triggers per source.
// Ports       : clk250_i      - 250 MHz clock
//               rst_i         - synchronous active-high reset
//               src_i         - trigger request pulses
//               src_en_i      - per-source enable
//               holdoff_i     - holdoff length after dead_i falls (0 = none)
//               dead_i        - buffer manager dead/busy
//               trig_o        - merged trigger pulse
//               trig_src_o    - contributing sources (valid with trig_o)
//               lost_sel_i    - lost counter readout select
//               lost_count_o  - selected lost count (1-cycle latency)
//               lost_clr_i    - clear all lost counters
//               ack_err_o     - sticky handshake timeout flag
//               state_o       - current FSM state
// Revision    : 1.0 - initial release
// ============================================================================
module anita3_trigger_arbiter
    import anita3_trig_pkg::*;
#(
    parameter int                 NUM_SRC     = 4,
    parameter logic [NUM_SRC-1:0] LATCH_MASK  = 4'b1110,
    parameter int                 ACK_TIMEOUT = 16,
    parameter int                 LOST_W      = 16
) (
    input  logic               clk250_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [NUM_SRC-1:0] src_en_i,
    input  logic [7:0]         holdoff_i,
    input  logic               dead_i,
    output logic               trig_o,
    output logic [NUM_SRC-1:0] trig_src_o,
    input  logic [1:0]         lost_sel_i,
    output logic [LOST_W-1:0]  lost_count_o,
    input  logic               lost_clr_i,
    output logic               ack_err_o,
    output logic [1:0]         state_o
);

    localparam int              ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    trig_state_e        state_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic               trig_q;
    logic [NUM_SRC-1:0] trig_src_q;
    logic [ACK_W-1:0]   ack_cnt_q;
    logic [7:0]         hold_cnt_q;
    logic               ack_err_q;
    logic [LOST_W-1:0]  lost_count_q, lost_count_d;

    logic               issue;
    logic [NUM_SRC-1:0] src_vld;
    logic [NUM_SRC-1:0] pend_set;
    logic [NUM_SRC-1:0] lost_inc;
    logic [LOST_W-1:0]  lost_val [NUM_SRC];

    // Source qualification and pend/lost bookkeeping.
    // On the issue edge the pend register is being emptied into trig_src_o,
    // so a latching arrival there starts the next trigger rather than being
    // merged (and is therefore not lost). Non-latching sources can only
    // become pending in an idle, not-dead cycle that is not an issue edge.
    always_comb begin
        issue    = (state_q == ST_IDLE) && (pend_q != '0) && !dead_i;
        src_vld  = src_i & src_en_i;
        pend_set = '0;
        lost_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_vld[i]) begin
                if (LATCH_MASK[i]) begin
                    pend_set[i] = 1'b1;
                    lost_inc[i] = pend_q[i] && !issue;
                end else if ((state_q != ST_IDLE) || dead_i || issue) begin
                    lost_inc[i] = 1'b1;
                end else begin
                    pend_set[i] = 1'b1;
                end
            end
        end
        // Set wins over the issue-edge clear
        pend_d = (issue ? '0 : pend_q) | pend_set;
    end

    always_ff @(posedge clk250_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            trig_q     <= 1'b0;
            trig_src_q <= '0;
            ack_cnt_q  <= '0;
            hold_cnt_q <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            trig_q     <= 1'b0;
            trig_src_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        trig_q     <= 1'b1;
                        trig_src_q <= pend_q;
                        ack_cnt_q  <= '0;
                        state_q    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (dead_i) begin
                        state_q <= ST_BUSY;
                    end else if (ack_cnt_q == ACK_LAST) begin
                        ack_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + ACK_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (!dead_i) begin
                        if (holdoff_i != 8'd0) begin
                            hold_cnt_q <= holdoff_i;
                            state_q    <= ST_HOLDOFF;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    // Leaving at a count of 1 yields exactly holdoff_i cycles here
                    if (hold_cnt_q == 8'd1) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_lost
            anita3_sat_counter #(
                .LOST_W (LOST_W)
            ) u_lost_cnt (
                .clk_i   (clk250_i),
                .rst_i   (rst_i),
                .inc_i   (lost_inc[g]),
                .clr_i   (lost_clr_i),
                .value_o (lost_val[g])
            );
        end
    endgenerate

    always_comb begin
        lost_count_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (lost_sel_i == 2'(i)) begin
                lost_count_d = lost_val[i];
            end
        end
    end

    always_ff @(posedge clk250_i) begin
        if (rst_i) begin
            lost_count_q <= '0;
        end else begin
            lost_count_q <= lost_count_d;
        end
    end

    assign trig_o       = trig_q;
    assign trig_src_o   = trig_src_q;
    assign ack_err_o    = ack_err_q;
    assign state_o      = state_q;
    assign lost_count_o = lost_count_q;

endmodule
`default_nettype wire

// File: tb/tb_anita3_trigger_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_anita3_trigger_arbiter
// Description : Directed self-checking bench for anita3_trigger_arbiter.
//               Inputs change and outputs are sampled 1 time unit after
//               each rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anita3_trigger_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src;
    logic [3:0]  src_en;
    logic [7:0]  holdoff;
    logic        dead;
    logic        trig;
    logic [3:0]  trig_src;
    logic [1:0]  lost_sel;
    logic [15:0] lost_count;
    logic        lost_clr;
    logic        ack_err;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    anita3_trigger_arbiter dut (
        .clk250_i     (clk),
        .rst_i        (rst),
        .src_i        (src),
        .src_en_i     (src_en),
        .holdoff_i    (holdoff),
        .dead_i       (dead),
        .trig_o       (trig),
        .trig_src_o   (trig_src),
        .lost_sel_i   (lost_sel),
        .lost_count_o (lost_count),
        .lost_clr_i   (lost_clr),
        .ack_err_o    (ack_err),
        .state_o      (state)
    );

    always #2 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        src      = 4'b0000;
        src_en   = 4'b1111;
        holdoff  = 8'd0;
        dead     = 1'b0;
        lost_sel = 2'd0;
        lost_clr = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_trig",     32'(trig),       32'h0);
        check("rst_trig_src", 32'(trig_src),   32'h0);
        check("rst_state",    32'(state),      32'h0);
        check("rst_ack_err",  32'(ack_err),    32'h0);
        check("rst_lost",     32'(lost_count), 32'h0);
        rst = 1'b0;
        repeat (6) tick();

        // Single RF pulse, dead tied low -> trigger, then ACK timeout
        src = 4'b0001;
        tick();
        src = 4'b0000;
        check("rf_no_trig_yet", 32'(trig), 32'h0);
        tick();
        check("rf_trig",     32'(trig),     32'h1);
        check("rf_trig_src", 32'(trig_src), 32'h1);
        check("rf_state_ack", 32'(state),   32'h1);
        repeat (15) tick();
        check("ack_still_waiting", 32'(state),   32'h1);
        check("ack_err_not_yet",   32'(ack_err), 32'h0);
        tick();
        check("ack_timeout_state", 32'(state),   32'h0);
        check("ack_err_set",       32'(ack_err), 32'h1);

        // RF+soft together, holdoff 5; soft+RF pulse during BUSY
        holdoff = 8'd5;
        src = 4'b1001;
        tick();
        src = 4'b0000;
        tick();
        check("merge_trig",     32'(trig),     32'h1);
        check("merge_trig_src", 32'(trig_src), 32'h9);
        tick();
        check("merge_one_pulse", 32'(trig), 32'h0);
        tick();
        dead = 1'b1;
        tick();
        check("busy_state", 32'(state), 32'h2);
        for (int i = 0; i < 19; i++) begin
            if (i == 5) src = 4'b1001;
            tick();
            src = 4'b0000;
        end
        check("busy_still", 32'(state), 32'h2);
        dead = 1'b0;
        tick();
        check("holdoff_entry", 32'(state), 32'h3);
        repeat (4) tick();
        check("holdoff_5th_cycle", 32'(state), 32'h3);
        tick();
        check("holdoff_exit_idle", 32'(state), 32'h0);
        check("holdoff_exit_no_trig", 32'(trig), 32'h0);
        tick();
        check("busy_soft_trig",     32'(trig),     32'h1);
        check("busy_soft_trig_src", 32'(trig_src), 32'h8);
        lost_sel = 2'd0;
        tick();
        check("rf_lost_busy", 32'(lost_count), 32'h1);

        // Two soft pulses during HOLDOFF -> one trigger, one lost
        dead = 1'b1;
        tick();
        check("busy2_state", 32'(state), 32'h2);
        dead = 1'b0;
        tick();
        check("holdoff2_entry", 32'(state), 32'h3);
        src = 4'b1000;
        tick();
        src = 4'b0000;
        tick();
        src = 4'b1000;
        tick();
        src = 4'b0000;
        tick();
        tick();
        check("holdoff2_exit", 32'(state), 32'h0);
        tick();
        check("hold_soft_trig",     32'(trig),     32'h1);
        check("hold_soft_trig_src", 32'(trig_src), 32'h8);
        lost_sel = 2'd3;
        tick();
        check("soft_lost", 32'(lost_count), 32'h1);
        dead = 1'b1;
        tick();
        dead = 1'b0;
        holdoff = 8'd0;
        tick();
        check("no_holdoff_idle", 32'(state), 32'h0);

        // RF disabled -> ignored, not counted
        src_en = 4'b1110;
        src = 4'b0001;
        tick();
        src = 4'b0000;
        tick();
        check("dis_no_trig_a", 32'(trig), 32'h0);
        tick();
        check("dis_no_trig_b", 32'(trig), 32'h0);
        lost_sel = 2'd0;
        tick();
        check("dis_rf_lost_unchanged", 32'(lost_count), 32'h1);
        src_en = 4'b1111;

        // Clear, then saturate the RF lost counter with dead held high
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        tick();
        check("lost_clr", 32'(lost_count), 32'h0);
        dead = 1'b1;
        src  = 4'b0001;
        repeat (65535) tick();
        src = 4'b0000;
        tick();
        check("lost_sat_ffff", 32'(lost_count), 32'hFFFF);
        check("sat_no_trig",   32'(trig),       32'h0);
        src = 4'b0001;
        tick();
        src = 4'b0000;
        tick();
        tick();
        check("lost_sat_hold", 32'(lost_count), 32'hFFFF);
        src      = 4'b0001;
        lost_clr = 1'b1;
        tick();
        src      = 4'b0000;
        lost_clr = 1'b0;
        tick();
        check("clr_beats_inc", 32'(lost_count), 32'h0);
        dead = 1'b0;
        tick();

        // Reset while BUSY with a pending soft trigger
        src = 4'b0100;
        tick();
        src = 4'b0000;
        tick();
        check("pps2_trig_src", 32'(trig_src), 32'h4);
        dead = 1'b1;
        tick();
        check("pps2_busy", 32'(state), 32'h2);
        src = 4'b1000;
        tick();
        src = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dead = 1'b0;
        check("mid_rst_state",   32'(state),   32'h0);
        check("mid_rst_trig",    32'(trig),    32'h0);
        check("mid_rst_ack_err", 32'(ack_err), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_trig", 32'(trig), 32'h0);
        end
        check("post_rst_idle", 32'(state), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
